core_if_pc_gen: RTL and testbench
=================================

CORE_IF_PC_GEN -- requirements
Module: core_if_pc_gen

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  single core clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  output  1  fetch request to instruction memory.
REQ-005 req_ready  input  1  memory accepts the request when req_valid & req_ready.
REQ-006 req_addr  output  `CORE_XLEN  fetch address, always the current PC.
REQ-007 rsp_valid  input  1  instruction returned for the oldest accepted request.
REQ-008 rsp_inst  input  `CORE_INST_WIDTH  returned instruction word.
REQ-009 flag_jal, flag_jalr, flag_branch  input  1 each  pre-decode class of rsp_inst, combinational, same cycle.
REQ-010 bj_imm  input  `CORE_XLEN  pre-decoded branch/jump immediate of rsp_inst.
REQ-011 out_valid  output  1  decoded-stage instruction valid.
REQ-012 out_ready  input  1  downstream accepts on out_valid & out_ready.
REQ-013 out_inst, out_pc  output  `CORE_INST_WIDTH / `CORE_XLEN  instruction and its address.
REQ-014 out_pred_taken  output  1  static prediction applied to out_inst.
REQ-015 flush_valid  input  1  redirect from execute (mispredict/jalr/exception).
REQ-016 flush_pc  input  `CORE_XLEN  redirect target.

Function
REQ-017 FSM states: REQ (request pending), WAIT (one request outstanding), HOLD (instruction held in output register); at most one outstanding request.
REQ-018 REQ: req_valid=1; handshake -> WAIT; else stay.
REQ-019 WAIT: req_valid=0; on rsp_valid, instruction, its PC and prediction load into the output register, PC updates per REQ-021, -> HOLD.
REQ-020 HOLD: out_valid=1; on out_ready -> REQ (next fetch issued the following cycle); outputs stable while out_ready=0.
REQ-021 Next PC on response: flag_jal -> pc+bj_imm, pred 1; flag_branch with bj_imm[31]=1 (backward) -> pc+bj_imm, pred 1; forward branch, flag_jalr, other -> pc+4, pred 0.
REQ-022 All PC arithmetic modulo 2^`CORE_XLEN; wrap from 32'hFFFF_FFFC to 0 without error.
REQ-023 flush_valid has priority over every other event in the same cycle: PC<=flush_pc, out_valid<=0, state<=REQ.
REQ-024 Flush in WAIT: state -> REQ only after the outstanding response arrives; a 1-bit drop flag marks it, the response is discarded (not presented, no PC update), then REQ to flush_pc.
REQ-025 Flush in HOLD with out_ready=1 same cycle: instruction treated as not accepted (downstream discards by flush).
REQ-026 Flush in REQ with req_ready=1 same cycle: request counts as accepted and is dropped via REQ-024.
REQ-027 rsp_valid outside WAIT is ignored.
REQ-028 Sustained throughput: one instruction per 3 cycles minimum with zero-latency memory; no combinational path from out_ready to req_valid.

Reset
REQ-029 During rst: state=REQ, PC=RESET_PC, req_valid=1 after release, out_valid=0, out_inst=0, out_pc=0, out_pred_taken=0, drop flag=0.
REQ-030 rst asserted mid-transaction abandons it; a late rsp_valid after release in REQ is ignored per REQ-027.

Verification
REQ-031 Reset release, req_ready=1, rsp 32'h00000013 next cycle -> req_addr 8000_0000, out_pc 8000_0000, out_pred_taken 0, next req_addr 8000_0004.
REQ-032 JAL response with bj_imm 32'h0000_0100 at PC 8000_0010 -> out_pred_taken 1, next req_addr 8000_0110.
REQ-033 Branch bj_imm 32'hFFFF_FFF8 at 8000_0020 -> next 8000_0018, pred 1; bj_imm 32'h0000_0008 -> next 8000_0024, pred 0.
REQ-034 Flush to 8000_1000 while WAIT, response arrives 2 cycles later -> no out_valid for it, next req_addr 8000_1000.
REQ-035 out_ready held 0 for 5 cycles in HOLD -> out_* stable, req_valid 0; simultaneous flush_valid & out_ready -> out_valid 0 next cycle.
REQ-036 PC FFFF_FFFC non-branch -> next req_addr 0000_0000.

Source files
------------

// File: rtl/core_if_pc_gen_if.sv
// core_if_pc_gen_if: fetch-side bundle between the PC generator, instruction memory,
// the downstream decode stage and the execute-stage redirect.
//   master modport: PC generator view (drives the request and decoded-stage outputs)
//   slave modport : environment view (memory, decode stage, execute redirect)
// Signals:
//   req_valid/req_ready/req_addr          fetch request handshake
//   rsp_valid/rsp_inst                    instruction return for the outstanding request
//   flag_jal/flag_jalr/flag_branch/bj_imm pre-decode of rsp_inst, same cycle
//   out_valid/out_ready/out_inst/out_pc/out_pred_taken  decoded-stage handoff
//   flush_valid/flush_pc                  redirect from execute

`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif
`ifndef CORE_INST_WIDTH
`define CORE_INST_WIDTH 32
`endif

interface core_if_pc_gen_if;
   logic                        req_valid;
   logic                        req_ready;
   logic [`CORE_XLEN-1:0]       req_addr;
   logic                        rsp_valid;
   logic [`CORE_INST_WIDTH-1:0] rsp_inst;
   logic                        flag_jal;
   logic                        flag_jalr;
   logic                        flag_branch;
   logic [`CORE_XLEN-1:0]       bj_imm;
   logic                        out_valid;
   logic                        out_ready;
   logic [`CORE_INST_WIDTH-1:0] out_inst;
   logic [`CORE_XLEN-1:0]       out_pc;
   logic                        out_pred_taken;
   logic                        flush_valid;
   logic [`CORE_XLEN-1:0]       flush_pc;

   modport master (
      output req_valid, req_addr, out_valid, out_inst, out_pc, out_pred_taken,
      input  req_ready, rsp_valid, rsp_inst, flag_jal, flag_jalr, flag_branch, bj_imm,
             out_ready, flush_valid, flush_pc
   );

   modport slave (
      input  req_valid, req_addr, out_valid, out_inst, out_pc, out_pred_taken,
      output req_ready, rsp_valid, rsp_inst, flag_jal, flag_jalr, flag_branch, bj_imm,
             out_ready, flush_valid, flush_pc
   );
endinterface

// File: rtl/core_if_pc_gen.sv
// core_if_pc_gen: instruction-fetch PC generator with static branch prediction.
// Issues one fetch at a time, captures the returned instruction into an output register
// together with its PC and prediction, and steers the next fetch (backward branches and
// JAL predicted taken). Execute-stage redirects override everything.
// Ports:
//   clk  core clock, rising edge
//   rst  asynchronous active-high reset
//   bus  core_if_pc_gen_if.master (fetch request/response, decoded output, flush)
// Parameters:
//   RESET_PC  first fetch address after reset

`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif
`ifndef CORE_INST_WIDTH
`define CORE_INST_WIDTH 32
`endif

module core_if_pc_gen #(
   parameter logic [`CORE_XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic             clk,
   input  logic             rst,
   core_if_pc_gen_if.master bus
);

   localparam int unsigned XLEN = `CORE_XLEN;
   localparam int unsigned IW   = `CORE_INST_WIDTH;

   typedef enum logic [1:0] {
      StReq,
      StWait,
      StHold
   } state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   // Set when the outstanding response belongs to a fetch made obsolete by a flush.
   logic              drop_q, drop_d;
   logic [IW-1:0]     out_inst_q, out_inst_d;
   logic [XLEN-1:0]   out_pc_q, out_pc_d;
   logic              out_pred_q, out_pred_d;

   logic              pred_taken;
   logic [XLEN-1:0]   pc_seq;
   logic [XLEN-1:0]   pc_tgt;

   // Static prediction: JAL always taken, conditional branches taken when backward.
   always_comb begin
      pred_taken = bus.flag_jal | (bus.flag_branch & bus.bj_imm[XLEN-1]);
      pc_seq     = pc_q + XLEN'(4);
      pc_tgt     = pc_q + bus.bj_imm;
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      drop_d     = drop_q;
      out_inst_d = out_inst_q;
      out_pc_d   = out_pc_q;
      out_pred_d = out_pred_q;

      case (state_q)
         StReq: begin
            if (bus.req_ready) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (bus.rsp_valid) begin
               if (drop_q) begin
                  // Stale response: swallow it and fetch from the redirect target.
                  state_d = StReq;
                  drop_d  = 1'b0;
               end else begin
                  out_inst_d = bus.rsp_inst;
                  out_pc_d   = pc_q;
                  out_pred_d = pred_taken;
                  pc_d       = pred_taken ? pc_tgt : pc_seq;
                  state_d    = StHold;
               end
            end
         end
         StHold: begin
            if (bus.out_ready) begin
               state_d = StReq;
            end
         end
         default: begin
            state_d = StReq;
         end
      endcase

      // Redirect wins over every other event in the same cycle.
      if (bus.flush_valid) begin
         pc_d       = bus.flush_pc;
         out_inst_d = out_inst_q;
         out_pc_d   = out_pc_q;
         out_pred_d = out_pred_q;
         case (state_q)
            StReq: begin
               if (bus.req_ready) begin
                  // Request was accepted this cycle; its response must still be drained.
                  state_d = StWait;
                  drop_d  = 1'b1;
               end else begin
                  state_d = StReq;
               end
            end
            StWait: begin
               if (bus.rsp_valid) begin
                  // Outstanding response arrives right now and is discarded.
                  state_d = StReq;
                  drop_d  = 1'b0;
               end else begin
                  state_d = StWait;
                  drop_d  = 1'b1;
               end
            end
            default: begin
               state_d = StReq;
               drop_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StReq;
         pc_q       <= RESET_PC;
         drop_q     <= 1'b0;
         out_inst_q <= '0;
         out_pc_q   <= '0;
         out_pred_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         drop_q     <= drop_d;
         out_inst_q <= out_inst_d;
         out_pc_q   <= out_pc_d;
         out_pred_q <= out_pred_d;
      end
   end

   // Outputs come straight from state, so out_ready never reaches req_valid combinationally.
   assign bus.req_valid      = (state_q == StReq);
   assign bus.req_addr       = pc_q;
   assign bus.out_valid      = (state_q == StHold);
   assign bus.out_inst       = out_inst_q;
   assign bus.out_pc         = out_pc_q;
   assign bus.out_pred_taken = out_pred_q;

endmodule

// File: tb/tb_core_if_pc_gen.sv
module tb_core_if_pc_gen;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   core_if_pc_gen_if ifc ();

   core_if_pc_gen #(
      .RESET_PC(32'h8000_0000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ifc.req_ready   = 1'b0;
      ifc.rsp_valid   = 1'b0;
      ifc.rsp_inst    = '0;
      ifc.flag_jal    = 1'b0;
      ifc.flag_jalr   = 1'b0;
      ifc.flag_branch = 1'b0;
      ifc.bj_imm      = '0;
      ifc.out_ready   = 1'b0;
      ifc.flush_valid = 1'b0;
      ifc.flush_pc    = '0;
   endtask

   // Move the PC while in REQ by a redirect with no handshake.
   task automatic set_pc(input logic [31:0] pc);
      ifc.flush_valid = 1'b1;
      ifc.flush_pc    = pc;
      step();
      ifc.flush_valid = 1'b0;
   endtask

   // REQ -> WAIT -> HOLD with the given response; leaves the DUT in HOLD.
   task automatic fetch(input logic [31:0] inst, input logic jal, input logic jalr,
                        input logic br, input logic [31:0] imm);
      ifc.req_ready = 1'b1;
      step();
      ifc.req_ready   = 1'b0;
      ifc.rsp_valid   = 1'b1;
      ifc.rsp_inst    = inst;
      ifc.flag_jal    = jal;
      ifc.flag_jalr   = jalr;
      ifc.flag_branch = br;
      ifc.bj_imm      = imm;
      step();
      idle_inputs();
   endtask

   task automatic accept();
      ifc.out_ready = 1'b1;
      step();
      ifc.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      checks++;
      if (ifc.out_valid !== 1'b0 || ifc.out_inst !== 32'h0 || ifc.out_pc !== 32'h0 ||
          ifc.out_pred_taken !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b inst=%h pc=%h pred=%b, want 0 0 0 0",
                  ifc.out_valid, ifc.out_inst, ifc.out_pc, ifc.out_pred_taken);
      end
      #2 rst = 1'b0;
      step();
      checks++;
      if (ifc.req_valid !== 1'b1 || ifc.req_addr !== 32'h8000_0000) begin
         errors++;
         $display("FAIL reset_release: got req_valid=%b addr=%h, want 1 80000000",
                  ifc.req_valid, ifc.req_addr);
      end
   endtask

   task automatic test_sequential();
      fetch(32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 32'h8000_0000 ||
          ifc.out_inst !== 32'h0000_0013 || ifc.out_pred_taken !== 1'b0 ||
          ifc.req_valid !== 1'b0) begin
         errors++;
         $display("FAIL seq_hold: got v=%b pc=%h inst=%h pred=%b rv=%b, want 1 80000000 13 0 0",
                  ifc.out_valid, ifc.out_pc, ifc.out_inst, ifc.out_pred_taken, ifc.req_valid);
      end
      accept();
      checks++;
      if (ifc.req_valid !== 1'b1 || ifc.req_addr !== 32'h8000_0004 || ifc.out_valid !== 1'b0)
      begin
         errors++;
         $display("FAIL seq_next: got rv=%b addr=%h ov=%b, want 1 80000004 0",
                  ifc.req_valid, ifc.req_addr, ifc.out_valid);
      end
   endtask

   task automatic test_jal();
      set_pc(32'h8000_0010);
      fetch(32'h1000_006f, 1'b1, 1'b0, 1'b0, 32'h0000_0100);
      checks++;
      if (ifc.out_pred_taken !== 1'b1 || ifc.out_pc !== 32'h8000_0010) begin
         errors++;
         $display("FAIL jal_pred: got pred=%b pc=%h, want 1 80000010",
                  ifc.out_pred_taken, ifc.out_pc);
      end
      accept();
      checks++;
      if (ifc.req_addr !== 32'h8000_0110) begin
         errors++;
         $display("FAIL jal_next: got %h, want 80000110", ifc.req_addr);
      end
   endtask

   task automatic test_branch();
      set_pc(32'h8000_0020);
      fetch(32'hfe00_0ce3, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
      accept();
      checks++;
      if (ifc.out_pred_taken !== 1'b1 || ifc.req_addr !== 32'h8000_0018) begin
         errors++;
         $display("FAIL branch_back: got pred=%b next=%h, want 1 80000018",
                  ifc.out_pred_taken, ifc.req_addr);
      end
      set_pc(32'h8000_0020);
      fetch(32'h0000_0463, 1'b0, 1'b0, 1'b1, 32'h0000_0008);
      accept();
      checks++;
      if (ifc.out_pred_taken !== 1'b0 || ifc.req_addr !== 32'h8000_0024) begin
         errors++;
         $display("FAIL branch_fwd: got pred=%b next=%h, want 0 80000024",
                  ifc.out_pred_taken, ifc.req_addr);
      end
      // JALR with a backward-looking immediate is never predicted.
      set_pc(32'h8000_0040);
      fetch(32'h0000_8067, 1'b0, 1'b1, 1'b0, 32'hFFFF_FF00);
      accept();
      checks++;
      if (ifc.out_pred_taken !== 1'b0 || ifc.req_addr !== 32'h8000_0044) begin
         errors++;
         $display("FAIL jalr_seq: got pred=%b next=%h, want 0 80000044",
                  ifc.out_pred_taken, ifc.req_addr);
      end
   endtask

   task automatic test_flush_wait();
      set_pc(32'h8000_0080);
      ifc.req_ready = 1'b1;
      step();
      ifc.req_ready   = 1'b0;
      ifc.flush_valid = 1'b1;
      ifc.flush_pc    = 32'h8000_1000;
      step();
      ifc.flush_valid = 1'b0;
      checks++;
      if (ifc.req_valid !== 1'b0 || ifc.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_wait_hold: got rv=%b ov=%b, want 0 0", ifc.req_valid, ifc.out_valid);
      end
      step();
      ifc.rsp_valid = 1'b1;
      ifc.rsp_inst  = 32'hdead_beef;
      step();
      ifc.rsp_valid = 1'b0;
      checks++;
      if (ifc.out_valid !== 1'b0 || ifc.req_valid !== 1'b1 || ifc.req_addr !== 32'h8000_1000)
      begin
         errors++;
         $display("FAIL flush_wait_drop: got ov=%b rv=%b addr=%h, want 0 1 80001000",
                  ifc.out_valid, ifc.req_valid, ifc.req_addr);
      end
   endtask

   task automatic test_hold_stall();
      logic [31:0] pc0;
      logic [31:0] inst0;
      int          bad;
      bad = 0;
      set_pc(32'h8000_0200);
      fetch(32'h0010_0093, 1'b0, 1'b0, 1'b0, 32'h0);
      pc0   = 32'h8000_0200;
      inst0 = 32'h0010_0093;
      for (int i = 0; i < 5; i++) begin
         step();
         if (ifc.out_valid !== 1'b1 || ifc.out_pc !== pc0 || ifc.out_inst !== inst0 ||
             ifc.req_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL hold_stable: %0d unstable cycles, want 0", bad);
      end
      ifc.flush_valid = 1'b1;
      ifc.flush_pc    = 32'h8000_2000;
      ifc.out_ready   = 1'b1;
      step();
      idle_inputs();
      checks++;
      if (ifc.out_valid !== 1'b0 || ifc.req_valid !== 1'b1 || ifc.req_addr !== 32'h8000_2000)
      begin
         errors++;
         $display("FAIL hold_flush: got ov=%b rv=%b addr=%h, want 0 1 80002000",
                  ifc.out_valid, ifc.req_valid, ifc.req_addr);
      end
   endtask

   task automatic test_flush_req_handshake();
      ifc.flush_valid = 1'b1;
      ifc.flush_pc    = 32'h8000_3000;
      ifc.req_ready   = 1'b1;
      step();
      idle_inputs();
      checks++;
      if (ifc.req_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_req_accept: got rv=%b, want 0", ifc.req_valid);
      end
      ifc.rsp_valid = 1'b1;
      ifc.flag_jal  = 1'b1;
      ifc.bj_imm    = 32'h0000_0400;
      step();
      idle_inputs();
      checks++;
      if (ifc.out_valid !== 1'b0 || ifc.req_valid !== 1'b1 || ifc.req_addr !== 32'h8000_3000)
      begin
         errors++;
         $display("FAIL flush_req_drop: got ov=%b rv=%b addr=%h, want 0 1 80003000",
                  ifc.out_valid, ifc.req_valid, ifc.req_addr);
      end
   endtask

   task automatic test_ignore_rsp();
      ifc.rsp_valid = 1'b1;
      ifc.rsp_inst  = 32'h1234_5678;
      ifc.flag_jal  = 1'b1;
      ifc.bj_imm    = 32'h0000_0010;
      step();
      idle_inputs();
      checks++;
      if (ifc.out_valid !== 1'b0 || ifc.req_valid !== 1'b1 || ifc.req_addr !== 32'h8000_3000)
      begin
         errors++;
         $display("FAIL ignore_rsp: got ov=%b rv=%b addr=%h, want 0 1 80003000",
                  ifc.out_valid, ifc.req_valid, ifc.req_addr);
      end
   endtask

   task automatic test_wrap();
      set_pc(32'hFFFF_FFFC);
      fetch(32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (ifc.out_pc !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_pc: got %h, want fffffffc", ifc.out_pc);
      end
      accept();
      checks++;
      if (ifc.req_addr !== 32'h0000_0000) begin
         errors++;
         $display("FAIL wrap_next: got %h, want 00000000", ifc.req_addr);
      end
   endtask

   task automatic test_back_to_back();
      int bad;
      bad = 0;
      set_pc(32'h8000_0500);
      ifc.req_ready = 1'b1;
      ifc.rsp_valid = 1'b1;
      ifc.rsp_inst  = 32'h0000_0013;
      ifc.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         step();
         if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 32'h8000_0500 + 32'(4 * i)) bad++;
         step();
      end
      idle_inputs();
      checks++;
      if (bad != 0 || ifc.req_addr !== 32'h8000_050C) begin
         errors++;
         $display("FAIL back_to_back: %0d bad beats addr=%h, want 0 8000050c", bad, ifc.req_addr);
      end
   endtask

   task automatic test_rst_mid();
      set_pc(32'h8000_0600);
      ifc.req_ready = 1'b1;
      step();
      ifc.req_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (ifc.req_addr !== 32'h8000_0000 || ifc.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_async: got addr=%h ov=%b, want 80000000 0",
                  ifc.req_addr, ifc.out_valid);
      end
      step();
      rst = 1'b0;
      ifc.rsp_valid = 1'b1;
      ifc.rsp_inst  = 32'h0000_0013;
      step();
      idle_inputs();
      checks++;
      if (ifc.out_valid !== 1'b0 || ifc.req_valid !== 1'b1 || ifc.req_addr !== 32'h8000_0000)
      begin
         errors++;
         $display("FAIL rst_mid_late_rsp: got ov=%b rv=%b addr=%h, want 0 1 80000000",
                  ifc.out_valid, ifc.req_valid, ifc.req_addr);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      idle_inputs();
      test_reset();
      test_sequential();
      test_jal();
      test_branch();
      test_flush_wait();
      test_hold_stall();
      test_flush_req_handshake();
      test_ignore_rsp();
      test_wrap();
      test_back_to_back();
      test_rst_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
